// File: rtl/apb_controller_fsm.sv
// APB master sequencer of the AHB-to-APB bridge: turns each accepted AHB
// transfer into an APB SETUP/ACCESS pair and stalls the AHB master meanwhile.
module apb_controller_fsm #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [SEL_W-1:0]  tempselx,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    output logic [SEL_W-1:0]  Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Hresp
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_RENABLE = 3'd2,
        ST_WWAIT   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_WENABLE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_addr_q;
    logic [SEL_W-1:0]    r_sel_q;
    logic [SEL_W-1:0]    r_pselx;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_hreadyout;

    logic [ADDR_W-1:0]   w_addr_q;
    logic [SEL_W-1:0]    w_sel_q;
    logic [SEL_W-1:0]    w_pselx;
    logic                w_penable;
    logic                w_pwrite;
    logic [ADDR_W-1:0]   w_paddr;
    logic [DATA_W-1:0]   w_pwdata;
    logic                w_hreadyout;

    // Next state, then the output values to be held in that next state.
    always_comb begin
        w_next_state = r_state;
        w_addr_q     = r_addr_q;
        w_sel_q      = r_sel_q;
        w_pselx      = r_pselx;
        w_penable    = r_penable;
        w_pwrite     = r_pwrite;
        w_paddr      = r_paddr;
        w_pwdata     = r_pwdata;
        w_hreadyout  = r_hreadyout;

        case (r_state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid) begin
                    w_addr_q     = Haddr;
                    w_sel_q      = tempselx;
                    w_next_state = Hwrite ? ST_WWAIT : ST_READ;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ:  w_next_state = ST_RENABLE;
            ST_WWAIT: begin
                w_pwdata     = Hwdata;
                w_next_state = ST_WRITE;
            end
            ST_WRITE: w_next_state = ST_WENABLE;
            default: begin
                // Illegal encoding: fall back to IDLE with reset output values.
                w_next_state = ST_IDLE;
                w_pwrite     = 1'b0;
                w_paddr      = '0;
                w_pwdata     = '0;
            end
        endcase

        case (w_next_state)
            ST_READ: begin
                w_pselx     = w_sel_q;
                w_paddr     = w_addr_q;
                w_pwrite    = 1'b0;
                w_penable   = 1'b0;
                w_hreadyout = 1'b0;
            end
            ST_WRITE: begin
                w_pselx     = w_sel_q;
                w_paddr     = w_addr_q;
                w_pwrite    = 1'b1;
                w_penable   = 1'b0;
                w_hreadyout = 1'b0;
            end
            ST_RENABLE, ST_WENABLE: begin
                w_penable   = 1'b1;
                w_hreadyout = 1'b1;
            end
            ST_WWAIT: begin
                w_pselx     = '0;
                w_penable   = 1'b0;
                w_hreadyout = 1'b0;
            end
            default: begin
                w_pselx     = '0;
                w_penable   = 1'b0;
                w_hreadyout = 1'b1;
            end
        endcase
    end

    // State and registered APB/AHB outputs, synchronous active-low reset.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_state     <= ST_IDLE;
            r_addr_q    <= '0;
            r_sel_q     <= '0;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_hreadyout <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_addr_q    <= w_addr_q;
            r_sel_q     <= w_sel_q;
            r_pselx     <= w_pselx;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_hreadyout <= w_hreadyout;
        end
    end

    assign Pselx     = r_pselx;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign Hreadyout = r_hreadyout;
    assign Hrdata    = (r_state == ST_RENABLE) ? Prdata : '0;
    assign Hresp     = 2'b00;

endmodule

// File: tb/tb_apb_controller_fsm.sv
// Directed vector bench for apb_controller_fsm with an inline APB protocol check.
module tb_apb_controller_fsm;

    logic        Hclk;
    logic        Hresetn;
    logic        valid;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [2:0]  tempselx;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;

    apb_controller_fsm #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Haddr(Haddr),
        .Hwrite(Hwrite), .tempselx(tempselx), .Hwdata(Hwdata), .Prdata(Prdata),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
        .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hresp(Hresp)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct packed {
        logic        rstn;
        logic        vld;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [2:0]  e_psel;
        logic        e_pen;
        logic        e_pwr;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic        e_hrdy;
        logic [31:0] e_hrdata;
    } vec_t;

    localparam int unsigned NVEC = 25;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0]  prev_psel;
    logic        prev_pen;
    logic        prev_pwr;
    logic [31:0] prev_paddr;

    function automatic vec_t mkv(input logic rstn, input logic vld, input logic wr,
                                 input logic [31:0] addr, input logic [2:0] sel,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic [2:0] e_psel, input logic e_pen,
                                 input logic e_pwr, input logic [31:0] e_paddr,
                                 input logic [31:0] e_pwdata, input logic e_hrdy,
                                 input logic [31:0] e_hrdata);
        vec_t v;
        v.rstn = rstn; v.vld = vld; v.wr = wr; v.addr = addr; v.sel = sel;
        v.wdata = wdata; v.rdata = rdata; v.e_psel = e_psel; v.e_pen = e_pen;
        v.e_pwr = e_pwr; v.e_paddr = e_paddr; v.e_pwdata = e_pwdata;
        v.e_hrdy = e_hrdy; v.e_hrdata = e_hrdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock edge, then the protocol rules that must hold on every cycle.
    task automatic tick();
        @(posedge Hclk);
        #1;
        chk("hresp_okay", 32'(Hresp), 32'h0);
        if (Penable) begin
            chk("access_after_setup", 32'(prev_pen), 32'h0);
            chk("psel_stable", 32'(Pselx), 32'(prev_psel));
            chk("paddr_stable", Paddr, prev_paddr);
            chk("pwrite_stable", 32'(Pwrite), 32'(prev_pwr));
        end
        prev_psel  = Pselx;
        prev_pen   = Penable;
        prev_pwr   = Pwrite;
        prev_paddr = Paddr;
    endtask

    task automatic drive(input logic rstn, input logic vld, input logic wr,
                         input logic [31:0] addr, input logic [2:0] sel,
                         input logic [31:0] wdata, input logic [31:0] rdata);
        Hresetn = rstn; valid = vld; Hwrite = wr; Haddr = addr;
        tempselx = sel; Hwdata = wdata; Prdata = rdata;
    endtask

    initial begin
        int lat;
        logic found;
        logic [31:0] cap;

        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0);
        prev_psel = '0; prev_pen = 1'b0; prev_pwr = 1'b0; prev_paddr = '0;

        // Reset, single read, single write, back-to-back, ignored valid, sel=0, reset mid-write.
        vecs[0]  = mkv(0,0,0,32'h0,        3'b000,32'h0,        32'h0,        3'b000,0,0,32'h0,        32'h0,        1,32'h0);
        vecs[1]  = mkv(1,1,0,32'h8000_0010,3'b001,32'h0,        32'hDEAD_BEEF,3'b001,0,0,32'h8000_0010,32'h0,        0,32'h0);
        vecs[2]  = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'hDEAD_BEEF,3'b001,1,0,32'h8000_0010,32'h0,        1,32'hDEAD_BEEF);
        vecs[3]  = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'hDEAD_BEEF,3'b000,0,0,32'h8000_0010,32'h0,        1,32'h0);
        vecs[4]  = mkv(1,1,1,32'h8400_0020,3'b010,32'h0,        32'h0,        3'b000,0,0,32'h8000_0010,32'h0,        0,32'h0);
        vecs[5]  = mkv(1,0,0,32'h0,        3'b000,32'h1234_5678,32'h0,        3'b010,0,1,32'h8400_0020,32'h1234_5678,0,32'h0);
        vecs[6]  = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'h0,        3'b010,1,1,32'h8400_0020,32'h1234_5678,1,32'h0);
        vecs[7]  = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'h0,        3'b000,0,1,32'h8400_0020,32'h1234_5678,1,32'h0);
        vecs[8]  = mkv(1,1,1,32'h8800_0000,3'b100,32'h0,        32'h0,        3'b000,0,1,32'h8400_0020,32'h1234_5678,0,32'h0);
        vecs[9]  = mkv(1,0,0,32'h0,        3'b000,32'hAAAA_5555,32'h0,        3'b100,0,1,32'h8800_0000,32'hAAAA_5555,0,32'h0);
        vecs[10] = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'h0,        3'b100,1,1,32'h8800_0000,32'hAAAA_5555,1,32'h0);
        vecs[11] = mkv(1,1,0,32'h8000_0004,3'b001,32'h0,        32'hCAFE_0001,3'b001,0,0,32'h8000_0004,32'hAAAA_5555,0,32'h0);
        vecs[12] = mkv(1,1,1,32'h8C00_0000,3'b010,32'h0,        32'hCAFE_0001,3'b001,1,0,32'h8000_0004,32'hAAAA_5555,1,32'hCAFE_0001);
        vecs[13] = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'hCAFE_0001,3'b000,0,0,32'h8000_0004,32'hAAAA_5555,1,32'h0);
        vecs[14] = mkv(1,1,1,32'h9000_0000,3'b010,32'h0,        32'h0,        3'b000,0,0,32'h8000_0004,32'hAAAA_5555,0,32'h0);
        vecs[15] = mkv(1,1,0,32'h9400_0000,3'b001,32'h0F0F_0F0F,32'h0,        3'b010,0,1,32'h9000_0000,32'h0F0F_0F0F,0,32'h0);
        vecs[16] = mkv(1,1,1,32'h9800_0000,3'b100,32'h0,        32'h0,        3'b010,1,1,32'h9000_0000,32'h0F0F_0F0F,1,32'h0);
        vecs[17] = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'h0,        3'b000,0,1,32'h9000_0000,32'h0F0F_0F0F,1,32'h0);
        vecs[18] = mkv(1,1,0,32'h8000_0008,3'b000,32'h0,        32'h1111_2222,3'b000,0,0,32'h8000_0008,32'h0F0F_0F0F,0,32'h0);
        vecs[19] = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'h1111_2222,3'b000,1,0,32'h8000_0008,32'h0F0F_0F0F,1,32'h1111_2222);
        vecs[20] = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'h0,        3'b000,0,0,32'h8000_0008,32'h0F0F_0F0F,1,32'h0);
        vecs[21] = mkv(1,1,1,32'h8400_0040,3'b010,32'h0,        32'h0,        3'b000,0,0,32'h8000_0008,32'h0F0F_0F0F,0,32'h0);
        vecs[22] = mkv(1,0,0,32'h0,        3'b000,32'h5555_0000,32'h0,        3'b010,0,1,32'h8400_0040,32'h5555_0000,0,32'h0);
        vecs[23] = mkv(0,1,1,32'h8400_0040,3'b010,32'h0,        32'h0,        3'b000,0,0,32'h0,        32'h0,        1,32'h0);
        vecs[24] = mkv(1,0,0,32'h0,        3'b000,32'h0,        32'h0,        3'b000,0,0,32'h0,        32'h0,        1,32'h0);

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i].rstn, vecs[i].vld, vecs[i].wr, vecs[i].addr,
                  vecs[i].sel, vecs[i].wdata, vecs[i].rdata);
            tick();
            chk($sformatf("v%0d_pselx", i),   32'(Pselx),     32'(vecs[i].e_psel));
            chk($sformatf("v%0d_penable", i), 32'(Penable),   32'(vecs[i].e_pen));
            chk($sformatf("v%0d_pwrite", i),  32'(Pwrite),    32'(vecs[i].e_pwr));
            chk($sformatf("v%0d_paddr", i),   Paddr,          vecs[i].e_paddr);
            chk($sformatf("v%0d_pwdata", i),  Pwdata,         vecs[i].e_pwdata);
            chk($sformatf("v%0d_hready", i),  32'(Hreadyout), 32'(vecs[i].e_hrdy));
            chk($sformatf("v%0d_hrdata", i),  Hrdata,         vecs[i].e_hrdata);
        end

        // Read latency from the address-phase edge to the ACCESS cycle.
        drive(1'b1, 1'b1, 1'b0, 32'h8000_0020, 3'b001, 32'h0, 32'h7777_8888);
        lat = 0; found = 1'b0; cap = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            if (!found) begin
                tick();
                if (i == 1) valid = 1'b0;
                if (Penable && Hreadyout) begin
                    found = 1'b1; lat = i; cap = Hrdata;
                end
            end
        end
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_latency_hrdata", cap, 32'h7777_8888);
        tick();
        chk("rd_back_idle_psel", 32'(Pselx), 32'h0);

        // Write latency, with write data presented one cycle after the address.
        drive(1'b1, 1'b1, 1'b1, 32'h8400_0060, 3'b010, 32'h0, 32'h0);
        lat = 0; found = 1'b0; cap = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            if (!found) begin
                tick();
                if (i == 1) begin
                    valid  = 1'b0;
                    Hwdata = 32'hFEED_F00D;
                end
                if (i == 2) Hwdata = 32'h0;
                if (Penable && Hreadyout) begin
                    found = 1'b1; lat = i; cap = Pwdata;
                end
            end
        end
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_latency_pwdata", cap, 32'hFEED_F00D);
        chk("wr_latency_paddr", Paddr, 32'h8400_0060);
        tick();
        chk("wr_back_idle_hready", 32'(Hreadyout), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
